// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 17;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    StScan,
    StConfirm,
    StPressed,
    StRelease
  } state_e;

  // Nibble at index {row, col} holds the key code; row 0 sits in the low 16 bits.
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every 2^SCAN_DIV clocks.
module scan_tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  logic [SCAN_DIV-1:0] r_div;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_tick = &r_div;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronizes rows, walks the active-low column, debounces
// press and release, and reports each accepted key once.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] data
);

  localparam logic [3:0] DebMax = 4'(DEBOUNCE);
  localparam bit         DebOne = (DEBOUNCE == 1);

  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_sync;
  state_e      r_state;
  logic [1:0]  r_col_idx;
  logic [3:0]  r_col;
  logic [1:0]  r_row_idx;
  logic [3:0]  r_cnt;
  logic        r_lock;
  logic [1:0]  r_sweep;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_held;
  logic [31:0] r_data;

  logic        w_tick;
  logic        w_hit;
  logic [1:0]  w_hit_row;
  logic        w_same;
  logic [3:0]  w_cnt_inc;
  logic [3:0]  w_new_code;
  logic        w_accept;
  logic        w_release;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .i_clock(clock),
    .i_reset(reset),
    .o_tick (w_tick)
  );

  always_comb begin
    w_hit     = (r_row_sync != 4'hF);
    w_hit_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_sync[i]) w_hit_row = 2'(i);
    end
    w_same     = w_hit && (w_hit_row == r_row_idx);
    w_cnt_inc  = r_cnt + 4'd1;
    w_new_code = KEYMAP[{w_hit_row, r_col_idx, 2'b00} +: 4];
    w_accept   = w_tick &&
                 ((r_state == StScan && w_hit && !r_lock && DebOne) ||
                  (r_state == StConfirm && w_same && w_cnt_inc == DebMax));
    w_release  = w_tick && !w_hit &&
                 ((r_state == StPressed && DebOne) ||
                  (r_state == StRelease && w_cnt_inc == DebMax));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_row_meta  <= 4'hF;
      r_row_sync  <= 4'hF;
      r_state     <= StScan;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_row_idx   <= 2'd0;
      r_cnt       <= 4'd0;
      r_lock      <= 1'b0;
      r_sweep     <= 2'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_data      <= 32'd0;
    end else begin
      r_row_meta  <= ROW;
      r_row_sync  <= r_row_meta;
      r_key_valid <= 1'b0;
      if (w_accept) begin
        r_key_valid <= 1'b1;
        r_key_code  <= w_new_code;
        r_data      <= {r_data[27:0], w_new_code};
        r_key_held  <= 1'b1;
        r_row_idx   <= w_hit_row;
        r_cnt       <= 4'd0;
        r_lock      <= 1'b1;
        r_sweep     <= 2'd0;
        r_state     <= StPressed;
      end else if (w_release) begin
        r_key_held <= 1'b0;
        r_col_idx  <= r_col_idx + 2'd1;
        r_col      <= {r_col[2:0], r_col[3]};
        r_cnt      <= 4'd0;
        r_state    <= StScan;
      end else if (w_tick) begin
        unique case (r_state)
          StScan: begin
            if (!w_hit) begin
              r_col_idx <= r_col_idx + 2'd1;
              r_col     <= {r_col[2:0], r_col[3]};
              // Lock clears only after a full column sweep sees no key down.
              if (r_lock) begin
                if (r_sweep == 2'd3) r_lock <= 1'b0;
                r_sweep <= r_sweep + 2'd1;
              end
            end else if (r_lock) begin
              r_sweep <= 2'd0;
            end else begin
              r_row_idx <= w_hit_row;
              r_cnt     <= 4'd1;
              r_state   <= StConfirm;
            end
          end
          StConfirm: begin
            if (w_same) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_cnt   <= 4'd0;
              r_state <= StScan;
            end
          end
          StPressed: begin
            if (!w_hit) begin
              r_cnt   <= 4'd1;
              r_state <= StRelease;
            end
          end
          StRelease: begin
            if (!w_hit) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_cnt   <= 4'd0;
              r_state <= StPressed;
            end
          end
          default: r_state <= StScan;
        endcase
      end
    end
  end

  assign COL       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign data      = r_data;

endmodule
